// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 serial receiver with oversampled bit recovery.
// The raw line is synchronised and framed by a start-edge-aligned tick generator.
// Received bytes are presented with a valid/ack handshake and sticky error flags.
module uart_rx_core #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rx_ack,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TCK_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TCK_W-1:0] TICK_LAST = TCK_W'(OVERSAMPLE - 1);
    localparam logic [TCK_W-1:0] TICK_HALF = TCK_W'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_rxd_s;
    logic             r_prev_s;
    logic [DIV_W-1:0] r_div_cnt;
    logic [TCK_W-1:0] r_tick_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_dlv;
    logic             r_ferr;

    logic w_start;
    logic w_tick;

    assign w_start = r_prev_s & ~r_rxd_s;
    assign w_tick  = (r_div_cnt == DIV_LAST);

    // Two-flop synchroniser plus one delayed copy for start-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b1;
            r_rxd_s  <= 1'b1;
            r_prev_s <= 1'b1;
        end else begin
            r_sync1  <= rxd;
            r_rxd_s  <= r_sync1;
            r_prev_s <= r_rxd_s;
        end
    end

    // Oversample tick divider, re-phased to the frame on each accepted start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_cnt <= '0;
        end else if ((r_state == S_IDLE) && w_start) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Frame FSM: start validation, data shift, stop check, break lockout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '1;
            r_dlv      <= 1'b0;
            r_ferr     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_dlv  <= 1'b0;
            r_ferr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_tick_cnt <= '0;
                        r_state    <= S_START;
                        busy       <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == TICK_HALF) begin
                            r_tick_cnt <= '0;
                            if (!r_rxd_s) begin
                                r_bit_idx <= '0;
                                r_state   <= S_DATA;
                            end else begin
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_tick_cnt == TICK_LAST) begin
                            r_tick_cnt <= '0;
                            r_shift    <= {r_rxd_s, r_shift[7:1]};
                            if (r_bit_idx == 3'd7) begin
                                r_state <= S_STOP;
                            end else begin
                                r_bit_idx <= r_bit_idx + 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_tick_cnt == TICK_LAST) begin
                            r_tick_cnt <= '0;
                            if (r_rxd_s) begin
                                r_dlv   <= 1'b1;
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                            end else begin
                                r_ferr  <= 1'b1;
                                r_state <= S_WAIT_IDLE;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (r_rxd_s) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Consumer-facing byte register and sticky flags; event sets beat clears
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (r_dlv) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end

            if (r_dlv && rx_valid && !rx_ack) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end

            if (r_ferr) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 160 clk per bit (DIV=10, OVERSAMPLE=16).
// Sent good bytes are queued and popped when the receiver delivers them.
module tb_uart_rx_core;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic       rx_ack;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int unsigned n_assert;
    int unsigned n_fail;
    logic [7:0]  exp_q[$];

    localparam int unsigned BITCLK = 160;

    uart_rx_core #(
        .CLK_FREQ  (1_600_000),
        .BAUD      (10_000),
        .OVERSAMPLE(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .rx_ack   (rx_ack),
        .err_clr  (err_clr),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one 8N1 frame; good-stop frames are expected back from the DUT
    task automatic send_frame(input logic [7:0] b, input logic stop);
        if (stop) exp_q.push_back(b);
        rxd = 1'b0;
        step(BITCLK);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            step(BITCLK);
        end
        rxd = stop;
        step(BITCLK);
    endtask

    task automatic chk_rx(input string tag);
        logic [7:0] e;
        chk({tag, "_queue_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, 32'(rx_data), 32'(e));
        end
    endtask

    initial begin
        int unsigned lat;
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b0;
        rxd      = 1'b1;
        rx_ack   = 1'b0;
        err_clr  = 1'b0;
        step(5);
        chk("reset_rx_data", 32'(rx_data), 32'h00);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        step(20);

        // 1: good frame 0xA5, latency from falling edge, then ack
        fork
            send_frame(8'hA5, 1'b1);
            begin
                lat = 0;
                while (!rx_valid && lat < 2000) begin
                    step(1);
                    lat++;
                end
            end
        join
        $display("t1 latency = %0d clk", lat);
        chk("t1_latency_window", 32'(lat >= 1514 && lat <= 1534), 32'd1);
        chk_rx("t1");
        chk("t1_frame_err", 32'(frame_err), 32'd0);
        rx_ack = 1'b1;
        step(1);
        rx_ack = 1'b0;
        chk("t1_ack_clears_valid", 32'(rx_valid), 32'd0);
        step(20);

        // 2: 40-clk glitch is rejected at the mid-start sample
        rxd = 1'b0;
        step(20);
        chk("t2_busy_during_glitch", 32'(busy), 32'd1);
        step(20);
        rxd = 1'b1;
        step(50);
        chk("t2_busy_cleared", 32'(busy), 32'd0);
        chk("t2_no_valid", 32'(rx_valid), 32'd0);
        chk("t2_no_frame_err", 32'(frame_err), 32'd0);
        chk("t2_no_overrun", 32'(overrun), 32'd0);
        step(20);

        // 3: bad stop with held-low line, then a good byte, then err_clr
        send_frame(8'h3C, 1'b0);
        step(240);
        chk("t3_frame_err", 32'(frame_err), 32'd1);
        chk("t3_no_valid", 32'(rx_valid), 32'd0);
        chk("t3_busy_held", 32'(busy), 32'd1);
        rxd = 1'b1;
        step(5);
        chk("t3_busy_released", 32'(busy), 32'd0);
        step(20);
        send_frame(8'h55, 1'b1);
        chk_rx("t3_55");
        chk("t3_valid", 32'(rx_valid), 32'd1);
        chk("t3_frame_err_sticky", 32'(frame_err), 32'd1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("t3_err_clr", 32'(frame_err), 32'd0);
        rx_ack = 1'b1;
        step(1);
        rx_ack = 1'b0;
        chk("t3_ack", 32'(rx_valid), 32'd0);
        step(20);

        // 4: two bytes without ack -> overrun, err_clr keeps the byte valid
        send_frame(8'h11, 1'b1);
        chk_rx("t4_11");
        chk("t4_no_overrun_first", 32'(overrun), 32'd0);
        send_frame(8'h22, 1'b1);
        chk_rx("t4_22");
        chk("t4_valid", 32'(rx_valid), 32'd1);
        chk("t4_overrun", 32'(overrun), 32'd1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("t4_overrun_cleared", 32'(overrun), 32'd0);
        chk("t4_valid_kept", 32'(rx_valid), 32'd1);
        step(20);

        // 5: ack lands in the delivery cycle of 0x7E while 0x22 is unread
        fork
            send_frame(8'h7E, 1'b1);
            begin : ack_in_delivery
                int unsigned n;
                n = 0;
                while (!busy && n < 100) begin
                    step(1);
                    n++;
                end
                while (busy && n < 3000) begin
                    step(1);
                    n++;
                end
                chk("t5_busy_fall_seen", 32'(n < 3000), 32'd1);
                rx_ack = 1'b1;
                step(1);
                rx_ack = 1'b0;
            end
        join
        chk_rx("t5_7E");
        chk("t5_valid", 32'(rx_valid), 32'd1);
        chk("t5_no_overrun", 32'(overrun), 32'd0);
        step(20);

        // 6: reset during bit 4 of 0x5A, then a clean 0x81 frame
        rxd = 1'b0;
        step(BITCLK);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'((8'h5A >> i) & 8'h01);
            step(BITCLK);
        end
        rxd = 1'b1;
        step(BITCLK / 2);
        chk("t6_busy_before_reset", 32'(busy), 32'd1);
        reset = 1'b0;
        step(10);
        chk("t6_rx_data", 32'(rx_data), 32'h00);
        chk("t6_rx_valid", 32'(rx_valid), 32'd0);
        chk("t6_frame_err", 32'(frame_err), 32'd0);
        chk("t6_overrun", 32'(overrun), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        step(5);
        reset = 1'b1;
        step(200);
        chk("t6_idle_after_release", 32'(busy), 32'd0);
        send_frame(8'h81, 1'b1);
        chk_rx("t6_81");
        chk("t6_valid", 32'(rx_valid), 32'd1);
        chk("t6_frame_err_after", 32'(frame_err), 32'd0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
